// File: rtl/bufdev_pkg.sv
// Shared types and constants for the device-output buffer and its upstream
// device-address controller.
package bufdev_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_DEPTH  = 8;

  // Address the controller decodes to divert a CPU store into this buffer.
  localparam logic [31:0] DEVICE_ADDR = 32'd900000;

  typedef logic [DEFAULT_DATA_W-1:0]         data_t;
  typedef logic [$clog2(DEFAULT_DEPTH):0]    cnt_t;

endpackage

// File: rtl/bufdev_mem.sv
// DEPTH x DATA_W register array: synchronous write port, asynchronous read
// port. Contents are deliberately not reset.
module bufdev_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/buffer_dispositivo.sv
// First-word-fall-through FIFO between the device-address controller and a
// slow output device. Optional sticky drop flag: BUFDEV_OVERFLOW_FLAG_EN.
module buffer_dispositivo
  import bufdev_pkg::*;
#(
  parameter int  DATA_W = DEFAULT_DATA_W,
  parameter int  DEPTH  = DEFAULT_DEPTH,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  output logic              dev_valid,
  output logic [DATA_W-1:0] dev_data,
  input  logic              dev_ready,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] head_data;
  logic              full_w;
  logic              valid_w;
  logic              push_ok;
  logic              pop_ok;
  logic              drop;

  // Device handshake: a word transfers on a rising edge where dev_valid and
  // dev_ready are both 1. dev_valid never depends on dev_ready, and while
  // dev_valid=1 and dev_ready=0 the head word is held unchanged.
  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign valid_w = (count_q != '0);

  // Full is judged on registered state, so a same-cycle pop does not make
  // room for a push; the pushed word is simply dropped.
  assign push_ok = wr_en & ~full_w;
  assign drop    = wr_en & full_w;
  assign pop_ok  = valid_w & dev_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  bufdev_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk_i   (clock),
    .we_i    (push_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_data)
  );

  assign full      = full_w;
  assign count     = count_q;
  assign dev_valid = valid_w;
  assign dev_data  = valid_w ? head_data : '0;

`ifdef BUFDEV_OVERFLOW_FLAG_EN
  logic ovf_q, ovf_d;

  // A drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_clr | drop;
  assign overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_buffer_dispositivo.sv
// Directed bench for buffer_dispositivo: reset, FWFT drain, overflow/drop,
// streaming with pointer wrap, push-while-full-and-pop, async reset.
module tb_buffer_dispositivo;
  import bufdev_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

`ifdef BUFDEV_OVERFLOW_FLAG_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic              clock;
  logic              reset;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic              dev_valid;
  logic [DATA_W-1:0] dev_data;
  logic              dev_ready;
  logic              overflow;
  logic              ovf_clr;

  int n_cmp = 0;
  int n_err = 0;
  logic [DATA_W-1:0] exp_q[$];

  buffer_dispositivo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .count     (count),
    .dev_valid (dev_valid),
    .dev_data  (dev_data),
    .dev_ready (dev_ready),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] v);
    wr_en   = 1'b1;
    wr_data = v;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(dev_valid), 32'd0);
    chk({tag, "_data"},  dev_data,        32'd0);
    chk({tag, "_count"}, 32'(count),     32'd0);
    chk({tag, "_full"},  32'(full),      32'd0);
  endtask

  // scoreboard: drain exp_q through the device port
  task automatic drain_check(input string tag);
    dev_ready = 1'b1;
    while (exp_q.size() > 0) begin
      chk({tag, "_head"}, dev_data, exp_q.pop_front());
      tick();
    end
    dev_ready = 1'b0;
    chk({tag, "_empty"}, 32'(dev_valid), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    wr_en     = 1'b0;
    wr_data   = '0;
    dev_ready = 1'b0;
    ovf_clr   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // reset state with no stimulus
    chk_idle("rst");
    chk("rst_ovf", 32'(overflow), 32'd0);

    // three words, stalled device, then drain
    push(32'h11);
    chk("lat_valid", 32'(dev_valid), 32'd1);
    chk("lat_data",  dev_data,        32'h11);
    push(32'h22);
    push(32'h33);
    tick();
    tick();
    chk("hold_data",  dev_data,    32'h11);
    chk("hold_count", 32'(count), 32'd3);
    dev_ready = 1'b1;
    chk("d3_data", dev_data, 32'h11);
    tick();
    chk("d3_cnt2", 32'(count), 32'd2);
    chk("d3_data", dev_data,    32'h22);
    tick();
    chk("d3_cnt1", 32'(count), 32'd1);
    chk("d3_data", dev_data,    32'h33);
    tick();
    dev_ready = 1'b0;
    chk_idle("d3_end");

    // nine pushes into eight entries: 0xA8 dropped
    for (int i = 0; i < 8; i++) begin
      push(32'hA0 + 32'(i));
      exp_q.push_back(32'hA0 + 32'(i));
    end
    chk("fill_full",  32'(full),  32'd1);
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_ovf0",  32'(overflow), 32'd0);
    push(32'hA8);
    chk("drop_count", 32'(count),    32'd8);
    chk("drop_ovf",   32'(overflow), 32'(OVF_EXP));
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    drain_check("fill");

    // continuous streaming, pointers wrap twice
    dev_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      wr_en   = 1'b1;
      wr_data = 32'(k);
      if (k > 1) chk("stream_head", dev_data, 32'(k - 1));
      tick();
      chk("stream_count", 32'(count), 32'd1);
    end
    wr_en = 1'b0;
    chk("stream_last", dev_data, 32'h10);
    tick();
    dev_ready = 1'b0;
    chk_idle("stream_end");

    // full FIFO: push 0xFF while popping, with a coincident ovf_clr
    for (int i = 0; i < 8; i++) push(32'hB0 + 32'(i));
    for (int i = 1; i < 8; i++) exp_q.push_back(32'hB0 + 32'(i));
    wr_en     = 1'b1;
    wr_data   = 32'hFF;
    dev_ready = 1'b1;
    ovf_clr   = 1'b1;
    chk("fp_head", dev_data, 32'hB0);
    tick();
    wr_en     = 1'b0;
    ovf_clr   = 1'b0;
    dev_ready = 1'b0;
    chk("fp_count", 32'(count),    32'd7);
    chk("fp_full",  32'(full),     32'd0);
    chk("fp_ovf",   32'(overflow), 32'(OVF_EXP));
    drain_check("fp");
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("fp_ovf_clr", 32'(overflow), 32'd0);

    // asynchronous reset with 5 words buffered and device stalled
    for (int i = 0; i < 5; i++) push(32'hC0 + 32'(i));
    chk("ar_count", 32'(count), 32'd5);
    #1;
    reset = 1'b1;
    #1;
    chk_idle("ar");
    chk("ar_ovf", 32'(overflow), 32'd0);
    #1;
    reset = 1'b0;
    push(32'h55);
    chk("ar_first", dev_data,    32'h55);
    chk("ar_cnt1",  32'(count), 32'd1);
    dev_ready = 1'b1;
    tick();
    dev_ready = 1'b0;
    chk_idle("ar_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/buffer_dispositivo.md
Name: buffer_dispositivo

Overview:
- Downstream stage of the device-address controller. Consumes the device-data word the controller diverts on a device-address write and buffers it in a small FIFO.
- Drains buffered words to the external output device over a valid/ready handshake, so the CPU never stalls on a slow device.
- Exposes full/count status for CPU polling.

Parameters:
DATA_W, 32, width of device data word
DEPTH, 8, FIFO entries; power of two, minimum 2
CNT_W, $clog2(DEPTH)+1, width of occupancy counter (derived, not overridden)

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-high reset
wr_en  input  1  one-cycle strobe from controller: device write this cycle
wr_data  input  DATA_W  device data word (controller's data_device)
full  output  1  FIFO holds DEPTH entries
count  output  CNT_W  current occupancy, 0..DEPTH
dev_valid  output  1  head word presented to device
dev_data  output  DATA_W  head word
dev_ready  input  1  device accepts head word this cycle
overflow  output  1  sticky drop flag (see Optional Feature)
ovf_clr  input  1  clears overflow (see Optional Feature)

Behaviour:
- Interface: one clock (clock); reset is asynchronous and active-high (reset).
- Reset values: full=0, count=0, dev_valid=0, dev_data=0, overflow=0. Read/write pointers=0. Storage array not reset.
- Reset mid-operation discards all buffered words immediately. No partial handshake survives.
- Push: on the rising edge with wr_en=1 and registered full=0, write wr_data at wr_ptr, increment wr_ptr modulo DEPTH.
- Dropped push: wr_en=1 while full=1 discards the word. This holds even if a pop occurs in the same cycle, because full is evaluated on registered state.
- Pop: on the rising edge with dev_valid=1 and dev_ready=1, increment rd_ptr modulo DEPTH. dev_ready while dev_valid=0 has no effect.
- Count update: push only: +1. Pop only: -1. Accepted push and pop together: unchanged. Count never exceeds DEPTH or goes below 0.
- Status decode: full = (count==DEPTH). dev_valid = (count!=0).
- Head presentation: first-word-fall-through. dev_data = mem[rd_ptr] when dev_valid=1, forced to 0 when empty.
- Latency: word pushed at edge N appears on dev_valid/dev_data after edge N, i.e. 1 cycle.
- No bypass: push into an empty FIFO is never consumed in the same cycle.
- Hold rule: dev_data and dev_valid stay stable while dev_valid=1 and dev_ready=0.
- Ordering: strict FIFO. Pointer wrap-around is transparent.
- Simultaneous push+pop at count=1: head advances to the new word; count stays 1.

Optional Feature:
- Macro: BUFDEV_OVERFLOW_FLAG_EN.
- Defined: overflow sets on any dropped push (wr_en=1 while full=1). It remains set until ovf_clr=1 at a rising edge. If a drop and ovf_clr coincide, set wins.
- Not defined: overflow tied to 0, ovf_clr ignored. Ports remain present so instantiations are unchanged.

Decomposition:
- Package bufdev_pkg contains:
  - DATA_W default
  - DEVICE_ADDR = 900000 (shared with the controller's decode)
  - typedef data_t (logic [DATA_W-1:0])
  - typedef cnt_t
- One sub-module: bufdev_mem, a DEPTH x DATA_W register array with a synchronous write port and an asynchronous read port.
- Pointers, count, flags and handshake logic stay in buffer_dispositivo.

Test Plan:
- Reset, then no stimulus -> dev_valid=0, dev_data=0, count=0, full=0, overflow=0.
- Push 0x11, 0x22, 0x33 with dev_ready=0, then dev_ready=1 for 3 cycles -> dev_data sequence 0x11, 0x22, 0x33; count 3→0; dev_valid drops after the third accept.
- Push 9 words 0xA0..0xA8 with DEPTH=8 and dev_ready=0 -> full=1 after the 8th push; 0xA8 dropped; drain yields 0xA0..0xA7; overflow=1 only with BUFDEV_OVERFLOW_FLAG_EN, and it clears after an ovf_clr pulse.
- Continuous push 0x01..0x10 with dev_ready=1 every cycle -> count holds at 1 in steady state; output order 0x01..0x10 with 1-cycle latency; pointers wrap twice without corruption.
- Full FIFO with wr_en=1 (0xFF) and dev_ready=1 in the same cycle -> 0xFF dropped, count 8→7, head advances.
- Assert reset with 5 words buffered while the device is stalled -> all outputs return to reset values asynchronously; the next push (0x55) appears as the first dev_data.
